sr_alu_mc: RTL

- Parametrised multi-cycle ALU; the successor to the single-cycle schoolRISCV ALU.
- Adds a valid/ready handshake on both sides, registered results, AND/SLL/SRA, and an optional iterative multiply/divide unit.
- Sits between decode and writeback in the multi-cycle core variant.
- The core stalls on in_ready/out_valid instead of assuming single-cycle execution.

---
 rtl/sr_alu_mc_if.sv | 25 ++
 rtl/sr_alu_mc.sv | 107 ++++++++++
 2 files changed

// File: rtl/sr_alu_mc_if.sv
// sr_alu_mc_if: request/response handshake bundle for sr_alu_mc.
//   master (producer/consumer side): drives in_valid, srcA, srcB, oper, out_ready.
//   slave  (ALU side): drives in_ready, out_valid, result, zero, busy.
interface sr_alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       oper;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  modport master (
    output in_valid, srcA, srcB, oper, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );
  modport slave (
    input  in_valid, srcA, srcB, oper, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/sr_alu_mc.sv
// sr_alu_mc: multi-cycle ALU with valid/ready handshake and optional iterative MUL/DIVU/REMU.
//   clk, rst : clock and synchronous active-high reset
//   bus      : sr_alu_mc_if.slave (in_valid/in_ready, srcA, srcB, oper,
//              out_valid/out_ready, result, zero, busy)
//   Define SR_ALU_MDU_EN to build the iterative multiply/divide unit;
//   otherwise opcodes 9-11 execute as ADD in one cycle.
module sr_alu_mc #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  sr_alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result, w_alu, w_res;
  logic             r_zero, w_accept, w_iter, w_fin;
  logic [SHW-1:0]   w_sh;
  assign w_sh          = bus.srcB[SHW-1:0];
  assign bus.in_ready  = r_state == IDLE || (r_state == DONE && bus.out_ready);
  assign bus.out_valid = r_state == DONE;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign w_accept      = bus.in_valid && bus.in_ready;
  always_comb begin
    case (bus.oper)
      4'd1:    w_alu = bus.srcA | bus.srcB;
      4'd2:    w_alu = bus.srcA >> w_sh;
      4'd3:    w_alu = {{(WIDTH-1){1'b0}}, bus.srcA < bus.srcB};
      4'd4:    w_alu = bus.srcA - bus.srcB;
      4'd5:    w_alu = bus.srcA ^ bus.srcB;
      4'd6:    w_alu = bus.srcA & bus.srcB;
      4'd7:    w_alu = bus.srcA << w_sh;
      4'd8:    w_alu = WIDTH'($signed(bus.srcA) >>> w_sh);
      default: w_alu = bus.srcA + bus.srcB;
    endcase
  end
`ifdef SR_ALU_MDU_EN
  // Shared iteration registers.
  //   MUL : r_x = partial product, r_y = multiplicand (<<1), r_z = multiplier (>>1)
  //   DIV : r_x = remainder, r_y = dividend shifting out / quotient shifting in, r_z = divisor
  // A zero divisor never fails the trial subtraction, which yields an all-ones
  // quotient and leaves the dividend as the remainder with no special case.
  logic [WIDTH-1:0] r_x, r_y, r_z, w_x_nxt, w_y_nxt, w_z_nxt;
  logic [WIDTH:0]   w_rsh, w_diff;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             w_mul;
  assign w_iter   = bus.oper inside {4'd9, 4'd10, 4'd11};
  assign w_fin    = r_state == BUSY && r_cnt == CW'(1);
  assign w_mul    = r_op == 2'd1;
  assign w_rsh    = {r_x, r_y[WIDTH-1]};
  assign w_diff   = w_rsh - {1'b0, r_z};
  assign w_x_nxt  = w_mul ? (r_z[0] ? r_x + r_y : r_x) : (w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0]);
  assign w_y_nxt  = w_mul ? r_y << 1 : {r_y[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_z_nxt  = w_mul ? r_z >> 1 : r_z;
  assign w_res    = w_fin ? (r_op == 2'd2 ? w_y_nxt : w_x_nxt) : w_alu;
  assign bus.busy = r_state == BUSY;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_op  <= '0;
      r_cnt <= '0;
    end else if (w_accept && w_iter) begin
      r_x   <= '0;
      r_y   <= bus.srcA;
      r_z   <= bus.srcB;
      r_op  <= bus.oper[1:0];
      r_cnt <= CW'(WIDTH);
    end else if (r_state == BUSY) begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_z   <= w_z_nxt;
      r_cnt <= r_cnt - CW'(1);
    end
  end
`else
  assign w_iter   = 1'b0;
  assign w_fin    = 1'b0;
  assign w_res    = w_alu;
  assign bus.busy = 1'b0;
`endif
  // A same-cycle accept in DONE takes priority over returning to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = w_iter ? BUSY : DONE;
    else if (w_fin) w_state_nxt = DONE;
    else if (r_state == DONE && bus.out_ready) w_state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if ((w_accept && !w_iter) || w_fin) begin
      r_result <= w_res;
      r_zero   <= w_res == '0;
    end
  end
endmodule
